// File: rtl/stream_word_serializer_if.sv
// Word-in / byte-out handshake bundle for stream_word_serializer.
// The slave view is the serializer; the master view is its upstream/downstream environment.
interface stream_word_serializer_if #(
    parameter int WORD_BYTES = 3
);
    logic [WORD_BYTES*8-1:0] i_word;
    logic                    i_valid;
    logic                    o_ready;
    logic [7:0]              o_data;
    logic                    o_valid;
    logic                    i_ready;

    modport slave (
        input  i_word,
        input  i_valid,
        output o_ready,
        output o_data,
        output o_valid,
        input  i_ready
    );

    modport master (
        output i_word,
        output i_valid,
        input  o_ready,
        input  o_data,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/stream_word_serializer.sv
// Serializes WORD_BYTES-wide words into an 8-bit valid/ready byte stream,
// optionally prefixing every FRAME_WORDS-word frame with SYNC_BYTE and a sequence number.
module stream_word_serializer #(
    parameter int         WORD_BYTES  = 3,
    parameter int         FRAME_WORDS = 256,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter bit         MSB_FIRST   = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    stream_word_serializer_if.slave stream,
    input  logic                    i_frame_en,
    output logic                    o_frame_start,
    output logic                    o_busy
);

    localparam int WORD_W = WORD_BYTES * 8;
    localparam int BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int WCNT_W = $clog2(FRAME_WORDS);
    localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(WORD_BYTES - 1);
    localparam logic [WCNT_W-1:0] LAST_WCNT = WCNT_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        S_EMPTY    = 2'd0,
        S_HDR_SYNC = 2'd1,
        S_HDR_SEQ  = 2'd2,
        S_DATA     = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [WORD_W-1:0]   word_q_r;
    logic [WORD_W-1:0]   word_q_nxt_s;
    logic [BIDX_W-1:0]   bidx_r;
    logic [BIDX_W-1:0]   bidx_nxt_s;
    logic [WCNT_W-1:0]   wcnt_r;
    logic [WCNT_W-1:0]   wcnt_nxt_s;
    logic [7:0]          seq_r;
    logic [7:0]          seq_nxt_s;
    logic                frame_active_r;
    logic                frame_active_nxt_s;

    logic                last_byte_s;
    logic                chain_s;
    logic                ready_s;
    logic                accept_s;
    logic [WCNT_W-1:0]   wcnt_done_s;
    logic [WCNT_W-1:0]   wcnt_base_s;
    logic                frame_bound_s;
    logic                frame_sel_s;
    logic [BIDX_W-1:0]   sel_s;
    logic [7:0]          data_byte_s;
    logic [7:0]          data_out_s;

    // Handshake terms and the frame-boundary view seen by a word accepted this cycle
    always_comb begin
        last_byte_s = (bidx_r == LAST_BIDX);
        chain_s     = (state_r == S_DATA) && last_byte_s && stream.i_ready;
        ready_s     = !i_rst && ((state_r == S_EMPTY) || chain_s);
        accept_s    = ready_s && stream.i_valid;
        if (!frame_active_r) begin
            wcnt_done_s = '0;
        end else if (wcnt_r == LAST_WCNT) begin
            wcnt_done_s = '0;
        end else begin
            wcnt_done_s = wcnt_r + WCNT_W'(1);
        end
        // A chained accept sees the counter as it will be after the current word completes
        if (state_r == S_DATA) begin
            wcnt_base_s = wcnt_done_s;
        end else begin
            wcnt_base_s = wcnt_r;
        end
        frame_bound_s = (wcnt_base_s == '0);
        frame_sel_s   = frame_bound_s ? i_frame_en : frame_active_r;
    end

    // Next-state and counter updates
    always_comb begin
        state_nxt_s        = state_r;
        word_q_nxt_s       = word_q_r;
        bidx_nxt_s         = bidx_r;
        wcnt_nxt_s         = wcnt_r;
        seq_nxt_s          = seq_r;
        frame_active_nxt_s = frame_active_r;
        case (state_r)
            S_EMPTY: begin
                state_nxt_s = S_EMPTY;
            end
            S_HDR_SYNC: begin
                if (stream.i_ready) begin
                    state_nxt_s = S_HDR_SEQ;
                end else begin
                    state_nxt_s = S_HDR_SYNC;
                end
            end
            S_HDR_SEQ: begin
                if (stream.i_ready) begin
                    seq_nxt_s   = seq_r + 8'd1;
                    bidx_nxt_s  = '0;
                    state_nxt_s = S_DATA;
                end else begin
                    state_nxt_s = S_HDR_SEQ;
                end
            end
            S_DATA: begin
                if (!stream.i_ready) begin
                    state_nxt_s = S_DATA;
                end else if (last_byte_s) begin
                    wcnt_nxt_s  = wcnt_done_s;
                    state_nxt_s = S_EMPTY;
                end else begin
                    bidx_nxt_s  = bidx_r + BIDX_W'(1);
                    state_nxt_s = S_DATA;
                end
            end
            default: begin
                state_nxt_s = S_EMPTY;
            end
        endcase
        if (accept_s) begin
            word_q_nxt_s       = stream.i_word;
            frame_active_nxt_s = frame_sel_s;
            bidx_nxt_s         = '0;
            if (frame_sel_s && frame_bound_s) begin
                state_nxt_s = S_HDR_SYNC;
            end else begin
                state_nxt_s = S_DATA;
            end
        end else begin
            word_q_nxt_s = word_q_nxt_s;
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r        <= S_EMPTY;
            word_q_r       <= '0;
            bidx_r         <= '0;
            wcnt_r         <= '0;
            seq_r          <= 8'h00;
            frame_active_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            word_q_r       <= word_q_nxt_s;
            bidx_r         <= bidx_nxt_s;
            wcnt_r         <= wcnt_nxt_s;
            seq_r          <= seq_nxt_s;
            frame_active_r <= frame_active_nxt_s;
        end
    end

    // Byte selection from the held word; only registered state feeds o_data
    always_comb begin
        if (MSB_FIRST) begin
            sel_s = LAST_BIDX - bidx_r;
        end else begin
            sel_s = bidx_r;
        end
        data_byte_s = 8'h00;
        for (int i = 0; i < WORD_BYTES; i++) begin
            data_byte_s = (sel_s == BIDX_W'(i)) ? word_q_r[i*8 +: 8] : data_byte_s;
        end
    end

    // Output byte mux by state
    always_comb begin
        case (state_r)
            S_EMPTY:    data_out_s = 8'h00;
            S_HDR_SYNC: data_out_s = SYNC_BYTE;
            S_HDR_SEQ:  data_out_s = seq_r;
            S_DATA:     data_out_s = data_byte_s;
            default:    data_out_s = 8'h00;
        endcase
    end

    assign stream.o_ready = ready_s;
    assign stream.o_valid = (state_r != S_EMPTY);
    assign stream.o_data  = data_out_s;
    assign o_busy         = (state_r != S_EMPTY);
    assign o_frame_start  = (state_r == S_HDR_SYNC) && stream.i_ready;

endmodule

// File: tb/tb_stream_word_serializer.sv
// Scoreboard bench for stream_word_serializer: a frame-level reference model predicts the byte
// stream at every accepted word; a negedge monitor pops and compares each transferred byte.
module tb_stream_word_serializer;

    localparam int         WB   = 3;
    localparam int         FW   = 4;
    localparam logic [7:0] SYNC = 8'hA5;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_frame_en;
    logic o_frame_start;
    logic o_busy;

    stream_word_serializer_if #(.WORD_BYTES(WB)) bus ();

    stream_word_serializer #(
        .WORD_BYTES (WB),
        .FRAME_WORDS(FW),
        .SYNC_BYTE  (SYNC),
        .MSB_FIRST  (1'b0)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .stream       (bus),
        .i_frame_en   (i_frame_en),
        .o_frame_start(o_frame_start),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [7:0] data;
        logic       sync;
        logic       seqb;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] obs_q[$];
    int         xfer_cyc_q[$];
    logic [7:0] seq_obs[$];
    int         fs_count = 0;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    // reference model state: position within frame, whether frame has headers, next seq number
    int         m_wcnt = 0;
    bit         m_frame = 1'b0;
    int         m_seq = 0;

    bit         rand_ready = 1'b0;
    logic       ready_fixed = 1'b1;
    bit         prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_accept(input logic [WB*8-1:0] w, input logic fe);
        if (m_wcnt == 0) m_frame = fe;
        if (m_frame && m_wcnt == 0) begin
            exp_q.push_back('{data: SYNC, sync: 1'b1, seqb: 1'b0});
            exp_q.push_back('{data: 8'(m_seq), sync: 1'b0, seqb: 1'b1});
            m_seq = (m_seq + 1) % 256;
        end
        for (int b = 0; b < WB; b++)
            exp_q.push_back('{data: w[b*8 +: 8], sync: 1'b0, seqb: 1'b0});
        m_wcnt = m_frame ? (m_wcnt + 1) % FW : 0;
    endtask

    always @(posedge i_clk) begin
        #1;
        bus.i_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    always @(negedge i_clk) begin
        exp_t e;
        logic xfer;
        cyc++;
        if (i_rst) begin
            check("reset_outputs",
                  {bus.o_valid, bus.o_ready, o_busy, o_frame_start, bus.o_data}, 32'd0);
            exp_q.delete();
            m_wcnt    = 0;
            m_frame   = 1'b0;
            m_seq     = 0;
            prev_hold = 1'b0;
        end else begin
            xfer = bus.o_valid && bus.i_ready;
            check("valid_busy", {bus.o_valid, o_busy}, {2{exp_q.size() != 0}});
            if (prev_hold)
                check("hold_stable", {bus.o_valid, bus.o_data}, {1'b1, prev_data});
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_byte: got %0h expected no byte", bus.o_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_fs", {bus.o_data, o_frame_start}, {e.data, e.sync});
                    obs_q.push_back(bus.o_data);
                    xfer_cyc_q.push_back(cyc);
                    if (e.seqb) seq_obs.push_back(bus.o_data);
                end
            end else begin
                check("frame_start_idle", o_frame_start, 32'd0);
            end
            if (o_frame_start) fs_count++;
            prev_hold = bus.o_valid && !bus.i_ready;
            prev_data = bus.o_data;
            if (bus.i_valid && bus.o_ready) model_accept(bus.i_word, i_frame_en);
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_word(input logic [WB*8-1:0] w);
        bus.i_word  = w;
        bus.i_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge i_clk);
            if (bus.o_ready) begin
                step();
                bus.i_valid = 1'b0;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: got no o_ready expected accept of %0h", w);
        step();
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 500; t++) begin
            @(negedge i_clk);
            if (exp_q.size() == 0 && !o_busy) begin
                step();
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL idle_timeout: got %0d bytes pending expected 0", exp_q.size());
        step();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) step();
        i_rst = 1'b0;
    endtask

    initial begin
        logic [7:0] t1[6];
        logic [7:0] t6[5];
        logic [7:0] seqv;
        int         a5_cnt;
        bit         found;

        t1 = '{8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB};
        t6 = '{8'hA5, 8'h00, 8'h56, 8'h34, 8'h12};
        i_rst       = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_word  = '0;
        i_frame_en  = 1'b0;
        repeat (3) step();
        i_rst = 1'b0;

        // back-to-back words, no framing
        obs_q.delete();
        xfer_cyc_q.delete();
        send_word(24'h123456);
        send_word(24'hABCDEF);
        wait_idle();
        check("t1_count", obs_q.size(), 32'd6);
        if (obs_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) check("t1_byte", obs_q[i], t1[i]);
            check("t1_no_bubble", 32'(xfer_cyc_q[5] - xfer_cyc_q[0]), 32'd5);
        end

        // two framed frames of four words
        do_reset();
        i_frame_en = 1'b1;
        obs_q.delete();
        fs_count = 0;
        for (int k = 0; k < 8; k++) send_word(24'($urandom));
        wait_idle();
        check("t2_count", obs_q.size(), 32'd28);
        check("t2_fs_pulses", fs_count, 32'd2);
        if (obs_q.size() >= 28) begin
            check("t2_sync0", obs_q[0], 32'hA5);
            check("t2_seq0", obs_q[1], 32'h00);
            check("t2_sync1", obs_q[14], 32'hA5);
            check("t2_seq1", obs_q[15], 32'h01);
        end

        // reset while byte 1 of a word is on the bus
        send_word(24'h123456);
        found = 1'b0;
        for (int t = 0; t < 50 && !found; t++) begin
            @(negedge i_clk);
            if (bus.o_valid && bus.o_data == 8'h34) found = 1'b1;
        end
        check("t6_reached_byte1", found, 32'd1);
        #1;
        i_rst = 1'b1;
        #1;
        check("t6_valid_drop", {bus.o_valid, bus.o_ready}, 32'd0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        obs_q.delete();
        send_word(24'h123456);
        wait_idle();
        check("t6_count", obs_q.size(), 32'd5);
        if (obs_q.size() >= 5)
            for (int i = 0; i < 5; i++) check("t6_byte", obs_q[i], t6[i]);

        // framing disabled after word 1 of a frame
        do_reset();
        i_frame_en = 1'b1;
        obs_q.delete();
        fs_count = 0;
        send_word(24'h010203);
        send_word(24'h040506);
        i_frame_en = 1'b0;
        for (int k = 2; k < 8; k++) send_word(24'h111111 * 24'(k));
        wait_idle();
        check("t5_fs_pulses", fs_count, 32'd1);
        check("t5_count", obs_q.size(), 32'd26);
        a5_cnt = 0;
        foreach (obs_q[i]) if (obs_q[i] == 8'hA5) a5_cnt++;
        check("t5_sync_bytes", a5_cnt, 32'd1);

        // sequence number wraps across 258 frames
        do_reset();
        i_frame_en = 1'b1;
        seq_obs.delete();
        for (int k = 0; k < 258 * FW; k++) send_word(24'($urandom));
        wait_idle();
        check("t4_seq_count", seq_obs.size(), 32'd258);
        if (seq_obs.size() >= 258)
            for (int k = 0; k < 258; k++) begin
                seqv = 8'(k);
                check("t4_seq", seq_obs[k], seqv);
            end

        // random handshakes and framing changes
        rand_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            if ($urandom_range(0, 15) == 0) i_frame_en = ~i_frame_en;
            send_word(24'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
        end
        rand_ready = 1'b0;
        wait_idle();
        check("t3_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
